// File: rtl/ula_arb_pkg.sv
// Shared definitions for the ULA arbiter: FSM encoding, default width and
// the flag bit positions agreed with the shared ULA.
package ula_arb_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Flag bit positions driven by the ULA on ula_flags.
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;

endpackage

// File: rtl/ula_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set req bit at or
// above ptr, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[pos]) begin
                valid = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin sharing of one combinational ULA among NUM_REQ cores:
// grant, register operands, capture result/flags, pulse done to the winner.
module ula_arbiter
    import ula_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = DEFAULT_DATA_W,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_opcode,
    input  logic [NUM_REQ*DATA_W-1:0] req_operand1,
    input  logic [NUM_REQ*DATA_W-1:0] req_operand2,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic [DATA_W-1:0]         flags,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic [DATA_W-1:0]         ula_opcode,
    output logic [DATA_W-1:0]         ula_operand1,
    output logic [DATA_W-1:0]         ula_operand2,
    input  logic [DATA_W-1:0]         ula_result,
    input  logic [DATA_W-1:0]         ula_flags,
    output logic [1:0]                fsm_state
);

    // Handshake: a core holds req high until granted; req is sampled only in
    // IDLE, the winner gets done[i] for one cycle, and must drop req by that
    // edge -- a req still high in the next IDLE cycle is a new request.

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_index;
    logic [DATA_W-1:0] sel_opcode;
    logic [DATA_W-1:0] sel_operand1;
    logic [DATA_W-1:0] sel_operand2;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .index (pick_index)
    );

    // Steer the winning core's slice onto the ULA input registers.
    always_comb begin
        sel_opcode   = '0;
        sel_operand1 = '0;
        sel_operand2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_index == IDX_W'(i)) begin
                sel_opcode   = req_opcode[i*DATA_W +: DATA_W];
                sel_operand1 = req_operand1[i*DATA_W +: DATA_W];
                sel_operand2 = req_operand2[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            grant_id     <= '0;
            ula_opcode   <= '0;
            ula_operand1 <= '0;
            ula_operand2 <= '0;
            result       <= '0;
            flags        <= '0;
            done         <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id     <= pick_index;
                        ula_opcode   <= sel_opcode;
                        ula_operand1 <= sel_operand1;
                        ula_operand2 <= sel_operand2;
                    end
                end
                EXEC: begin
                    result <= ula_result;
                    flags  <= ula_flags;
                    done   <= NUM_REQ'(1) << grant_id;
                end
                DONE: begin
                    // Next search starts just past the core we served.
                    ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == EXEC) || (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: transaction-level round-robin model feeding an
// expected queue, checked by an independent monitor on every done pulse.
module tb_ula_arbiter;
    import ula_arb_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int IW    = $clog2(N);
    localparam int EXP_W = 32 + IW + 2 * W;  // {done cycle, core, result, flags}

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_opcode;
    logic [N*W-1:0]   req_operand1;
    logic [N*W-1:0]   req_operand2;
    logic [N-1:0]     done;
    logic [W-1:0]     result;
    logic [W-1:0]     flags;
    logic             busy;
    logic [IW-1:0]    grant_id;
    logic [W-1:0]     ula_opcode;
    logic [W-1:0]     ula_operand1;
    logic [W-1:0]     ula_operand2;
    logic [W-1:0]     ula_result;
    logic [W-1:0]     ula_flags;
    logic [1:0]       fsm_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit running = 1'b0;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;
    int               served_core_q[$];
    int               served_cyc_q[$];
    logic [2*W-1:0]   served_val_q[$];

    int       m_ptr;
    int       m_wait;
    int       m_grant_cyc;
    int       m_core;
    bit [N-1:0] rerq;
    bit [N-1:0] rerq_pend;

    ula_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_opcode   (req_opcode),
        .req_operand1 (req_operand1),
        .req_operand2 (req_operand2),
        .done         (done),
        .result       (result),
        .flags        (flags),
        .busy         (busy),
        .grant_id     (grant_id),
        .ula_opcode   (ula_opcode),
        .ula_operand1 (ula_operand1),
        .ula_operand2 (ula_operand2),
        .ula_result   (ula_result),
        .ula_flags    (ula_flags),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ULA model: returns {flags, result} ----------------
    function automatic logic [2*W-1:0] ula_fn(input logic [W-1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic [W-1:0] f;
        s = '0;
        f = '0;
        case (op)
            8'h01: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                f[FLAG_CARRY] = s[W];
            end
            8'h02:   r = a - b;
            8'h03:   r = a & b;
            8'h04:   r = a ^ b;
            default: r = a;
        endcase
        f[FLAG_ZERO] = (r == '0);
        return {f, r};
    endfunction

    always_comb {ula_flags, ula_result} = ula_fn(ula_opcode, ula_operand1, ula_operand2);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (running && reset) begin
            check("busy", 64'(busy), 64'(cyc > m_grant_cyc && cyc <= m_grant_cyc + 2));
            if (done != '0) begin
                served_core_q.push_back(int'(grant_id));
                served_cyc_q.push_back(cyc);
                served_val_q.push_back({flags, result});
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(mon_e[EXP_W-1 -: 32]));
                    check("done_vec", 64'(done), 64'(N'(1) << mon_e[2*W +: IW]));
                    check("grant_id", 64'(grant_id), 64'(mon_e[2*W +: IW]));
                    check("result", 64'(result), 64'(mon_e[W +: W]));
                    check("flags", 64'(flags), 64'(mon_e[0 +: W]));
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0][EXP_W-1 -: 32]) <= cyc) begin
                mon_e = exp_q.pop_front();
                check("missing_done", 64'(done), 64'(N'(1) << mon_e[2*W +: IW]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [W-1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_opcode[i*W +: W]   = op;
        req_operand1[i*W +: W] = a;
        req_operand2[i*W +: W] = b;
        req[i] = 1'b1;
    endtask

    task automatic rand_req(input int i);
        set_req(i, W'($urandom_range(1, 5)), W'($urandom), W'($urandom));
    endtask

    // Core side: drop req on done, optionally re-request one cycle later.
    task automatic core_react();
        for (int i = 0; i < N; i++) begin
            if (rerq_pend[i]) begin
                rerq_pend[i] = 1'b0;
                if (rerq[i]) rand_req(i);
            end
            if (done[i]) begin
                req[i] = 1'b0;
                rerq_pend[i] = 1'b1;
            end
        end
    endtask

    // Reference: the arbiter is free every third cycle after a grant; when
    // free it serves the first requester from m_ptr upward.
    task automatic model_eval();
        int             pick;
        logic [IW-1:0]  p;
        logic [2*W-1:0] v;
        pick = -1;
        if (m_wait != 0) m_wait--;
        if (m_wait == 0 && req != '0) begin
            for (int k = 0; k < N; k++) begin
                p = IW'((m_ptr + k) % N);
                if (pick < 0 && req[p]) pick = int'(p);
            end
            v = ula_fn(req_opcode[pick*W +: W], req_operand1[pick*W +: W],
                       req_operand2[pick*W +: W]);
            exp_q.push_back({32'(cyc + 2), IW'(pick), v[W-1:0], v[2*W-1:W]});
            m_ptr       = (pick + 1) % N;
            m_core      = pick;
            m_grant_cyc = cyc;
            m_wait      = 3;
        end
    endtask

    task automatic cycle();
        model_eval();
        @(negedge clk);
        core_react();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((req != '0 || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 64'(req == '0 && exp_q.size() == 0), 64'(1));
        repeat (2) cycle();
    endtask

    task automatic clear_served();
        served_core_q.delete();
        served_cyc_q.delete();
        served_val_q.delete();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr       = 0;
        m_wait      = 0;
        m_grant_cyc = -100;
        m_core      = 0;
        rerq        = '0;
        rerq_pend   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_result"}, 64'(result), 64'(0));
        check({tag, "_flags"}, 64'(flags), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_grant_id"}, 64'(grant_id), 64'(0));
        check({tag, "_ula_opcode"}, 64'(ula_opcode), 64'(0));
        check({tag, "_ula_operand1"}, 64'(ula_operand1), 64'(0));
        check({tag, "_ula_operand2"}, 64'(ula_operand2), 64'(0));
        check({tag, "_state"}, 64'(fsm_state), 64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b0;
        req          = '0;
        req_opcode   = '0;
        req_operand1 = '0;
        req_operand2 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset   = 1'b1;
        running = 1'b1;

        // Contention: all four held, each drops on its own done.
        clear_served();
        for (int i = 0; i < N; i++) set_req(i, 8'h01, W'(i), W'(i + 1));
        run_until_idle(60);
        check("contention_count", 64'(served_core_q.size()), 64'(4));
        if (served_core_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check("contention_order", 64'(served_core_q[i]), 64'(i));
            for (int i = 0; i < 3; i++)
                check("contention_spacing", 64'(served_cyc_q[i+1] - served_cyc_q[i]), 64'(3));
        end

        // Pointer fairness: cores 0 and 2 keep re-requesting.
        clear_served();
        rerq = 4'b0101;
        rand_req(0);
        rand_req(2);
        repeat (24) cycle();
        rerq = '0;
        run_until_idle(60);
        check("fair_count_ok", 64'(served_core_q.size() >= 4), 64'(1));
        if (served_core_q.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                check("fair_order", 64'(served_core_q[i]), 64'((i % 2 == 0) ? 0 : 2));
        end

        // Single request, core 1: 3 + 4.
        clear_served();
        set_req(1, 8'h01, 8'h03, 8'h04);
        run_until_idle(30);
        if (served_val_q.size() == 1) begin
            check("single_core", 64'(served_core_q[0]), 64'(1));
            check("single_result", 64'(served_val_q[0][W-1:0]), 64'(8'h07));
            check("single_zero_flag", 64'(served_val_q[0][W + FLAG_ZERO]), 64'(0));
        end else begin
            check("single_count", 64'(served_val_q.size()), 64'(1));
        end

        // Operands change (and req drops) during EXEC: latched values win.
        clear_served();
        set_req(3, 8'h01, 8'h05, 8'h05);
        cycle();
        req_operand1[3*W +: W] = 8'hFF;
        req_operand2[3*W +: W] = 8'h01;
        req[3] = 1'b0;
        run_until_idle(30);
        if (served_val_q.size() == 1) begin
            check("latch_core", 64'(served_core_q[0]), 64'(3));
            check("latch_result", 64'(served_val_q[0][W-1:0]), 64'(8'h0A));
        end else begin
            check("latch_count", 64'(served_val_q.size()), 64'(1));
        end

        // Zero flag: 0x80 + 0x80.
        clear_served();
        set_req(0, 8'h01, 8'h80, 8'h80);
        run_until_idle(30);
        if (served_val_q.size() == 1) begin
            check("zero_result", 64'(served_val_q[0][W-1:0]), 64'(8'h00));
            check("zero_flag", 64'(served_val_q[0][W + FLAG_ZERO]), 64'(1));
        end else begin
            check("zero_count", 64'(served_val_q.size()), 64'(1));
        end

        // Randomized traffic with operand scrambling and post-grant drops.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && !rerq_pend[i] && $urandom_range(0, 2) == 0) rand_req(i);
                else if (req[i] && $urandom_range(0, 3) == 0) begin
                    req_operand1[i*W +: W] = W'($urandom);
                    req_operand2[i*W +: W] = W'($urandom);
                end
            end
            if (cyc == m_grant_cyc + 1 && $urandom_range(0, 3) == 0) req[m_core] = 1'b0;
            cycle();
        end
        run_until_idle(300);

        // Reset mid-EXEC: leave result nonzero and ptr at 2 first.
        set_req(1, 8'h01, 8'h11, 8'h22);
        run_until_idle(30);
        set_req(2, 8'h01, 8'h01, 8'h01);
        cycle();
        reset = 1'b0;
        #1;
        running = 1'b0;
        check_all_zero("async_reset");
        req = '0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("reset_hold_done", 64'(done), 64'(0));
        end
        reset   = 1'b1;
        running = 1'b1;
        repeat (4) cycle();
        clear_served();
        for (int i = 0; i < N; i++) rand_req(i);
        run_until_idle(60);
        check("post_reset_count", 64'(served_core_q.size()), 64'(4));
        if (served_core_q.size() != 0)
            check("post_reset_first", 64'(served_core_q[0]), 64'(0));

        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
